// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and entry layout, also imported by the
// rename table and reservation stations.
package reorder_buffer_pkg;

  localparam int TAG_W  = 5;
  localparam int DEPTH  = 1 << TAG_W;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [TAG_W:0]    count_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // Per-entry payload; the valid/ready flags live in separate vectors so
  // they can be reset and flushed without touching the payload storage.
  typedef struct packed {
    logic     has_dest;
    reg_idx_t dest;
    data_t    value;
  } rob_payload_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, lookup and commit signals of the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     flush;

  logic     alloc_valid;
  logic     alloc_has_dest;
  reg_idx_t alloc_dest;
  logic     alloc_ready;
  tag_t     alloc_tag;

  logic     wb_valid;
  tag_t     wb_tag;
  data_t    wb_value;
  logic     wb2_valid;
  tag_t     wb2_tag;
  data_t    wb2_value;

  tag_t     rs_tag;
  tag_t     rt_tag;
  logic     rs_ready;
  data_t    rs_value;
  logic     rt_ready;
  data_t    rt_value;

  logic     commit_valid;
  logic     commit_we;
  reg_idx_t commit_dest;
  tag_t     commit_tag;
  data_t    commit_value;
  logic     empty;

  // Core side: dispatch, CDB and operand requests
  modport master (
    output flush, alloc_valid, alloc_has_dest, alloc_dest,
           wb_valid, wb_tag, wb_value, wb2_valid, wb2_tag, wb2_value,
           rs_tag, rt_tag,
    input  alloc_ready, alloc_tag, rs_ready, rs_value, rt_ready, rt_value,
           commit_valid, commit_we, commit_dest, commit_tag, commit_value,
           empty
  );

  // Reorder buffer side
  modport slave (
    input  flush, alloc_valid, alloc_has_dest, alloc_dest,
           wb_valid, wb_tag, wb_value, wb2_valid, wb2_tag, wb2_value,
           rs_tag, rt_tag,
    output alloc_ready, alloc_tag, rs_ready, rs_value, rt_ready, rt_value,
           commit_valid, commit_we, commit_dest, commit_tag, commit_value,
           empty
  );

endinterface

// File: rtl/reorder_buffer_lookup_port.sv
// Combinational operand lookup of one ROB entry with same-cycle CDB bypass.
// CDB port 1 has priority over port 0, which has priority over storage.
module rob_lookup_port
  import reorder_buffer_pkg::*;
(
  input  tag_t  tag,
  input  logic  ent_valid,
  input  logic  ent_ready,
  input  data_t ent_value,
  input  logic  wb_valid,
  input  tag_t  wb_tag,
  input  data_t wb_value,
  input  logic  wb2_valid,
  input  tag_t  wb2_tag,
  input  data_t wb2_value,
  output logic  ready,
  output data_t value
);

  logic hit, hit2;

  assign hit  = wb_valid  && (wb_tag  == tag);
  assign hit2 = wb2_valid && (wb2_tag == tag);

  // Resolve ready/value for the looked-up entry
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ready = 1'b0;
    value = '0;
    if (ent_valid) begin
      ready = ent_ready | hit | hit2;
      if (hit2)           value = wb2_value;
      else if (hit)       value = wb_value;
      else if (ent_ready) value = ent_value;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, two CDB completions per cycle,
// two bypassed operand lookups, in-order single retirement, flush to empty.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] ready_q;
  rob_payload_t     payload_q [DEPTH];
  tag_t             head_q;
  tag_t             tail_q;
  count_t           count_q;

  logic grant;
  logic commit;

  // Full/empty come from the registered count only, so a commit in the same
  // cycle as a full buffer cannot open a slot until the next cycle.
  assign bus.alloc_ready = (count_q != count_t'(DEPTH));
  assign bus.alloc_tag   = tail_q;
  assign bus.empty       = (count_q == '0);
  assign grant           = bus.alloc_valid & bus.alloc_ready & ~bus.flush;

  // Retirement sees only stored results; CDB results become visible next cycle.
  assign commit           = valid_q[head_q] & ready_q[head_q] & ~bus.flush;
  assign bus.commit_valid = commit;
  assign bus.commit_we    = commit & payload_q[head_q].has_dest;
  assign bus.commit_dest  = commit ? payload_q[head_q].dest  : '0;
  assign bus.commit_value = commit ? payload_q[head_q].value : '0;
  assign bus.commit_tag   = head_q;

  // Entry flags and pointers; flush overrides every other update
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (grant) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (bus.wb_valid && valid_q[bus.wb_tag])
        ready_q[bus.wb_tag] <= 1'b1;
      if (bus.wb2_valid && valid_q[bus.wb2_tag])
        ready_q[bus.wb2_tag] <= 1'b1;
      if (commit) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + count_t'(grant) - count_t'(commit);
    end
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; it is never observed unless
    // the entry's valid/ready flags say so, which keeps it plain RAM.
    if (!bus.flush) begin
      if (grant) begin
        payload_q[tail_q].has_dest <= bus.alloc_has_dest;
        payload_q[tail_q].dest     <= bus.alloc_dest;
      end
      // Port 1 is written last so it wins when both ports hit the same tag.
      if (bus.wb_valid && valid_q[bus.wb_tag])
        payload_q[bus.wb_tag].value <= bus.wb_value;
      if (bus.wb2_valid && valid_q[bus.wb2_tag])
        payload_q[bus.wb2_tag].value <= bus.wb2_value;
    end
  end

  rob_lookup_port u_rs_lookup (
    .tag       (bus.rs_tag),
    .ent_valid (valid_q[bus.rs_tag]),
    .ent_ready (ready_q[bus.rs_tag]),
    .ent_value (payload_q[bus.rs_tag].value),
    .wb_valid  (bus.wb_valid),
    .wb_tag    (bus.wb_tag),
    .wb_value  (bus.wb_value),
    .wb2_valid (bus.wb2_valid),
    .wb2_tag   (bus.wb2_tag),
    .wb2_value (bus.wb2_value),
    .ready     (bus.rs_ready),
    .value     (bus.rs_value)
  );

  rob_lookup_port u_rt_lookup (
    .tag       (bus.rt_tag),
    .ent_valid (valid_q[bus.rt_tag]),
    .ent_ready (ready_q[bus.rt_tag]),
    .ent_value (payload_q[bus.rt_tag].value),
    .wb_valid  (bus.wb_valid),
    .wb_tag    (bus.wb_tag),
    .wb_value  (bus.wb_value),
    .wb2_valid (bus.wb2_valid),
    .wb2_tag   (bus.wb2_tag),
    .wb2_value (bus.wb2_value),
    .ready     (bus.rt_ready),
    .value     (bus.rt_value)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_passed;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (rob_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rob_bus.flush          = 1'b0;
    rob_bus.alloc_valid    = 1'b0;
    rob_bus.alloc_has_dest = 1'b0;
    rob_bus.alloc_dest     = '0;
    rob_bus.wb_valid       = 1'b0;
    rob_bus.wb_tag         = '0;
    rob_bus.wb_value       = '0;
    rob_bus.wb2_valid      = 1'b0;
    rob_bus.wb2_tag        = '0;
    rob_bus.wb2_value      = '0;
    rob_bus.rs_tag         = '0;
    rob_bus.rt_tag         = '0;
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    idle_inputs();
    rst = 1'b1;
    #2;

    // Reset state
    check("rst_alloc_ready", 32'(rob_bus.alloc_ready), 32'd1);
    check("rst_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
    check("rst_commit_valid", 32'(rob_bus.commit_valid), 32'd0);
    check("rst_commit_we", 32'(rob_bus.commit_we), 32'd0);
    check("rst_empty", 32'(rob_bus.empty), 32'd1);
    check("rst_rs_ready", 32'(rob_bus.rs_ready), 32'd0);
    check("rst_rt_ready", 32'(rob_bus.rt_ready), 32'd0);
    check("rst_rs_value", rob_bus.rs_value, 32'd0);
    check("rst_commit_value", rob_bus.commit_value, 32'd0);
    #10;
    rst = 1'b0;
    step();

    // Three allocations, dest 4, 5, 6
    for (int i = 0; i < 3; i++) begin
      rob_bus.alloc_valid    = 1'b1;
      rob_bus.alloc_has_dest = 1'b1;
      rob_bus.alloc_dest     = reg_idx_t'(4 + i);
      check("alloc_tag_seq", 32'(rob_bus.alloc_tag), 32'(i));
      check("alloc_no_commit", 32'(rob_bus.commit_valid), 32'd0);
      step();
      check("empty_after_alloc", 32'(rob_bus.empty), 32'd0);
    end
    rob_bus.alloc_valid = 1'b0;

    // Tag 1 completes first: head 0 still not ready
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = 5'd1;
    rob_bus.wb_value = 32'hAA;
    step();
    rob_bus.wb_valid = 1'b0;
    check("ooo_no_commit", 32'(rob_bus.commit_valid), 32'd0);

    // Tag 0 completes: no same-cycle bypass into commit
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = 5'd0;
    rob_bus.wb_value = 32'h11;
    check("no_cdb_commit_bypass", 32'(rob_bus.commit_valid), 32'd0);
    step();
    rob_bus.wb_valid = 1'b0;
    check("commit0_valid", 32'(rob_bus.commit_valid), 32'd1);
    check("commit0_tag", 32'(rob_bus.commit_tag), 32'd0);
    check("commit0_dest", 32'(rob_bus.commit_dest), 32'd4);
    check("commit0_we", 32'(rob_bus.commit_we), 32'd1);
    check("commit0_value", rob_bus.commit_value, 32'h11);
    step();
    check("commit1_valid", 32'(rob_bus.commit_valid), 32'd1);
    check("commit1_tag", 32'(rob_bus.commit_tag), 32'd1);
    check("commit1_dest", 32'(rob_bus.commit_dest), 32'd5);
    check("commit1_value", rob_bus.commit_value, 32'hAA);
    step();
    check("head2_not_ready", 32'(rob_bus.commit_valid), 32'd0);

    // Lookup bypass on tag 2 with port priority
    rob_bus.rs_tag    = 5'd2;
    rob_bus.wb2_valid = 1'b1;
    rob_bus.wb2_tag   = 5'd2;
    rob_bus.wb2_value = 32'h55;
    #1;
    check("rs_bypass_ready", 32'(rob_bus.rs_ready), 32'd1);
    check("rs_bypass_value", rob_bus.rs_value, 32'h55);
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = 5'd2;
    rob_bus.wb_value = 32'h66;
    rob_bus.rt_tag   = 5'd7;
    #1;
    check("rs_port1_priority", rob_bus.rs_value, 32'h55);
    check("rt_invalid_ready", 32'(rob_bus.rt_ready), 32'd0);
    check("rt_invalid_value", rob_bus.rt_value, 32'd0);
    step();
    rob_bus.wb_valid  = 1'b0;
    rob_bus.wb2_valid = 1'b0;
    check("rs_stored_ready", 32'(rob_bus.rs_ready), 32'd1);
    check("rs_stored_port1", rob_bus.rs_value, 32'h55);
    check("commit2_valid", 32'(rob_bus.commit_valid), 32'd1);
    check("commit2_value", rob_bus.commit_value, 32'h55);
    check("commit2_dest", 32'(rob_bus.commit_dest), 32'd6);
    step();
    check("drained_empty", 32'(rob_bus.empty), 32'd1);
    check("drained_alloc_tag", 32'(rob_bus.alloc_tag), 32'd3);

    // Five entries (tags 3..7), head completes, then flush
    for (int i = 0; i < 5; i++) begin
      rob_bus.alloc_valid    = 1'b1;
      rob_bus.alloc_has_dest = 1'b1;
      rob_bus.alloc_dest     = reg_idx_t'(10 + i);
      step();
    end
    rob_bus.alloc_valid = 1'b0;
    rob_bus.wb_valid    = 1'b1;
    rob_bus.wb_tag      = 5'd3;
    rob_bus.wb_value    = 32'h33;
    step();
    rob_bus.wb_valid = 1'b0;
    check("preflush_commit", 32'(rob_bus.commit_valid), 32'd1);
    check("preflush_tag", 32'(rob_bus.commit_tag), 32'd3);
    rob_bus.flush = 1'b1;
    #1;
    check("flush_blocks_commit", 32'(rob_bus.commit_valid), 32'd0);
    step();
    rob_bus.flush = 1'b0;
    check("postflush_empty", 32'(rob_bus.empty), 32'd1);
    check("postflush_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
    check("postflush_alloc_ready", 32'(rob_bus.alloc_ready), 32'd1);
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = 5'd4;
    rob_bus.wb_value = 32'h99;
    rob_bus.rs_tag   = 5'd4;
    #1;
    check("late_wb_lookup_ready", 32'(rob_bus.rs_ready), 32'd0);
    check("late_wb_lookup_value", rob_bus.rs_value, 32'd0);
    step();
    rob_bus.wb_valid = 1'b0;
    check("late_wb_ignored", 32'(rob_bus.rs_ready), 32'd0);
    check("late_wb_no_commit", 32'(rob_bus.commit_valid), 32'd0);
    check("late_wb_empty", 32'(rob_bus.empty), 32'd1);

    // Fill all 32 entries
    for (int i = 0; i < DEPTH; i++) begin
      rob_bus.alloc_valid    = 1'b1;
      rob_bus.alloc_has_dest = 1'b1;
      rob_bus.alloc_dest     = reg_idx_t'(i);
      step();
    end
    check("full_alloc_ready", 32'(rob_bus.alloc_ready), 32'd0);
    check("full_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
    check("full_not_empty", 32'(rob_bus.empty), 32'd0);
    step();
    check("req33_tag_held", 32'(rob_bus.alloc_tag), 32'd0);
    check("req33_ready_low", 32'(rob_bus.alloc_ready), 32'd0);

    // Complete and commit head while still requesting allocation
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = 5'd0;
    rob_bus.wb_value = 32'h77;
    step();
    rob_bus.wb_valid = 1'b0;
    check("full_commit_valid", 32'(rob_bus.commit_valid), 32'd1);
    check("full_commit_tag", 32'(rob_bus.commit_tag), 32'd0);
    check("full_commit_value", rob_bus.commit_value, 32'h77);
    check("full_commit_no_alloc", 32'(rob_bus.alloc_ready), 32'd0);
    step();
    check("after_commit_ready", 32'(rob_bus.alloc_ready), 32'd1);
    check("after_commit_wrap_tag", 32'(rob_bus.alloc_tag), 32'd0);
    check("after_commit_head1", 32'(rob_bus.commit_valid), 32'd0);
    step();
    rob_bus.alloc_valid = 1'b0;
    check("refill_ready_low", 32'(rob_bus.alloc_ready), 32'd0);
    check("refill_tag", 32'(rob_bus.alloc_tag), 32'd1);

    // Asynchronous reset mid-stream
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = 5'd1;
    rob_bus.wb_value = 32'h42;
    step();
    rob_bus.wb_valid = 1'b0;
    check("prereset_commit", 32'(rob_bus.commit_valid), 32'd1);
    check("prereset_value", rob_bus.commit_value, 32'h42);
    #2;
    rst = 1'b1;
    #1;
    check("async_commit_valid", 32'(rob_bus.commit_valid), 32'd0);
    check("async_commit_value", rob_bus.commit_value, 32'd0);
    check("async_commit_tag", 32'(rob_bus.commit_tag), 32'd0);
    check("async_empty", 32'(rob_bus.empty), 32'd1);
    check("async_alloc_ready", 32'(rob_bus.alloc_ready), 32'd1);
    check("async_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
    #10;
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
